muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 37 +++
 rtl/div_restoring_step.sv | 31 +++
 rtl/muldiv_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - MULDIV_XLEN : default operand/result width
//   - F3_*        : funct3 operation codes
//   - state_t     : control FSM encoding
//   - rs1_signed / rs2_signed : operand signedness per operation
package muldiv_pkg;

    localparam int MULDIV_XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // MUL and MULHU are treated as unsigned: the low product word is
    // identical either way, so MUL needs no sign handling.
    function automatic logic rs1_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV)  || (f3 == F3_REM);
    endfunction

    function automatic logic rs2_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/div_restoring_step.sv
// div_restoring_step: one combinational restoring-division iteration.
//   rem_in  : partial remainder (always < divisor)
//   quo_in  : remaining dividend bits, MSB shifted into the remainder,
//             new quotient bit shifted in at the LSB
//   divisor : divisor magnitude
//   rem_out / quo_out : updated partial remainder and quotient/dividend
module div_restoring_step
#(
    parameter int XLEN = 32
)
(
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          qbit;

    // rem_in < divisor, so shifted < 2*divisor and the trial difference
    // fits in XLEN+1 bits; its top bit is the borrow.
    assign shifted = {rem_in, quo_in[XLEN-1]};
    assign diff    = shifted - {1'b0, divisor};
    assign qbit    = ~diff[XLEN];
    assign rem_out = qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign quo_out = {quo_in[XLEN-2:0], qbit};

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV-M style multiply/divide unit.
//   Multiply is radix-2 shift-add on operand magnitudes (XLEN cycles);
//   divide is restoring division on magnitudes (XLEN cycles). Signs are
//   applied on the final iteration. Divide-by-zero and signed overflow
//   finish one cycle after start without iterating.
// Ports:
//   iCLK, iRST_n        : clock, async active-low reset
//   iStart, iFunct3     : start request and operation select (sampled in IDLE)
//   iRs1, iRs2          : operands
//   iFlush              : abort the current operation, no result
//   oBusy, oDone        : operation in flight / one-cycle result strobe
//   oResult             : last completed result (held between operations)
// Build option: define MULDIV_FAST_MUL_EN for a single-cycle combinational
//   multiplier; division is unaffected.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = MULDIV_XLEN
)
(
    input  logic            iCLK,
    input  logic            iRST_n,
    input  logic            iStart,
    input  logic [2:0]      iFunct3,
    input  logic [XLEN-1:0] iRs1,
    input  logic [XLEN-1:0] iRs2,
    input  logic            iFlush,
    output logic            oBusy,
    output logic            oDone,
    output logic [XLEN-1:0] oResult
);

    localparam int CW = $clog2(XLEN) + 1;

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? -v : v;
    endfunction

    state_t            state;
    logic [2:0]        f3_q;
    logic [XLEN-1:0]   rs1_q, rs2_q;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   rem, quo;
    logic              busy_q, done_q;
    logic [XLEN-1:0]   res_q;

    // In-flight operand signs and magnitudes
    logic            neg1, neg2;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            last_iter;

    assign neg1      = rs1_signed(f3_q) & rs1_q[XLEN-1];
    assign neg2      = rs2_signed(f3_q) & rs2_q[XLEN-1];
    assign a_mag     = neg1 ? -rs1_q : rs1_q;
    assign b_mag     = neg2 ? -rs2_q : rs2_q;
    assign last_iter = (cnt == CW'(XLEN - 1));

    // Multiply datapath
    logic [2*XLEN-1:0] prod_nxt;
    logic [2*XLEN-1:0] mul_prod;
    logic [XLEN-1:0]   mul_res;
    logic              mul_last;

`ifdef MULDIV_FAST_MUL_EN
    assign prod_nxt = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    assign mul_last = 1'b1;
`else
    // prod holds {partial sum, remaining multiplier bits}; each step adds
    // the multiplicand into the upper half when the multiplier LSB is set,
    // then shifts right with the carry.
    logic [XLEN:0] mul_sum;
    assign mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, {XLEN{prod[0]}} & a_mag};
    assign prod_nxt = {mul_sum, prod[XLEN-1:1]};
    assign mul_last = last_iter;
`endif

    assign mul_prod = (neg1 ^ neg2) ? -prod_nxt : prod_nxt;
    assign mul_res  = (f3_q == F3_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

    // Divide datapath
    logic [XLEN-1:0] rem_nxt, quo_nxt;
    logic [XLEN-1:0] q_fin, r_fin, div_res, div_spec;
    logic            div_zero, div_ovf;

    div_restoring_step #(.XLEN(XLEN)) u_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .divisor (b_mag),
        .rem_out (rem_nxt),
        .quo_out (quo_nxt)
    );

    assign q_fin    = (neg1 ^ neg2) ? -quo_nxt : quo_nxt;
    assign r_fin    = neg1 ? -rem_nxt : rem_nxt;
    assign div_res  = f3_q[1] ? r_fin : q_fin;
    assign div_zero = (rs2_q == '0);
    assign div_ovf  = rs1_signed(f3_q) & (rs1_q == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_q == '1);
    // funct3[1] selects the remainder flavour (REM/REMU)
    assign div_spec = div_zero ? (f3_q[1] ? rs1_q : '1) : (f3_q[1] ? '0 : rs1_q);

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state  <= S_IDLE;
            f3_q   <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            cnt    <= '0;
            prod   <= '0;
            rem    <= '0;
            quo    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            res_q  <= '0;
        end else if (iFlush) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (iStart) begin
                        f3_q   <= iFunct3;
                        rs1_q  <= iRs1;
                        rs2_q  <= iRs2;
                        cnt    <= '0;
                        prod   <= {{XLEN{1'b0}}, mag(iRs2, rs2_signed(iFunct3))};
                        rem    <= '0;
                        quo    <= mag(iRs1, rs1_signed(iFunct3));
                        busy_q <= 1'b1;
                        state  <= iFunct3[2] ? S_DIV : S_MUL;
                    end
                end
                S_MUL: begin
                    prod <= prod_nxt;
                    cnt  <= cnt + 1'b1;
                    if (mul_last) begin
                        res_q  <= mul_res;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DIV: begin
                    if (div_zero || div_ovf) begin
                        res_q  <= div_spec;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        cnt <= cnt + 1'b1;
                        if (last_iter) begin
                            res_q  <= div_res;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign oBusy   = busy_q;
    assign oDone   = done_q;
    assign oResult = res_q;

endmodule
